// File: rtl/rotation_amount_finder_if.sv
// Search request/result bundle for the rotation amount finder.
// master drives the request and the slave reports busy/done and the decoded rotation.
interface rotation_amount_finder_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] ref_in;
  logic [WIDTH-1:0] rot_in;
  logic             busy;
  logic             done;
  logic             found;
  logic             lr;
  logic [AMT_W-1:0] amount;

  modport master (
    output start, ref_in, rot_in,
    input  busy, done, found, lr, amount
  );

  modport slave (
    input  start, ref_in, rot_in,
    output busy, done, found, lr, amount
  );
endinterface

// File: rtl/rotation_amount_finder.sv
// Recovers the rotation (direction, amount) that maps ref_in onto rot_in, one candidate per clock.
// Latency k+1 cycles to done (max WIDTH); start is only sampled in IDLE, no queueing.
module rotation_amount_finder #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  rotation_amount_finder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [AMT_W-1:0] K_LAST = AMT_W'(WIDTH - 1);
  localparam logic [AMT_W-1:0] HALF   = AMT_W'(WIDTH / 2);
  localparam logic [AMT_W-1:0] ZERO   = '0;
  localparam logic [AMT_W-1:0] ONE    = AMT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] tgt;
  logic [AMT_W-1:0] k;
  logic             match;
  logic             last;
  logic             res_found;
  logic             res_lr;
  logic [AMT_W-1:0] res_amount;

  assign match = (sr == tgt);
  assign last  = (k == K_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SEARCH;
      SEARCH:  if (match || last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      SEARCH:  bus.busy = 1'b1;
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // sr walks through left rotations of ref; k is the rotation currently held in sr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      tgt        <= '0;
      k          <= '0;
      res_found  <= 1'b0;
      res_lr     <= 1'b0;
      res_amount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr  <= bus.ref_in;
            tgt <= bus.rot_in;
            k   <= '0;
          end
        end
        SEARCH: begin
          if (match) begin
            res_found <= 1'b1;
            // Up to half a turn reads as left; beyond that the shorter right rotation is reported.
            if (k <= HALF) begin
              res_lr     <= 1'b1;
              res_amount <= k;
            end else begin
              res_lr     <= 1'b0;
              res_amount <= ZERO - k;
            end
          end else if (last) begin
            res_found  <= 1'b0;
            res_lr     <= 1'b0;
            res_amount <= '0;
          end else begin
            sr <= {sr[WIDTH-2:0], sr[WIDTH-1]};
            k  <= k + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.found  = res_found;
  assign bus.lr     = res_lr;
  assign bus.amount = res_amount;

endmodule

// File: tb/tb_rotation_amount_finder.sv
// Directed and randomized checks of rotation_amount_finder against a search-by-arithmetic model.
module tb_rotation_amount_finder;
  localparam int W = 8;
  localparam int A = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rotation_amount_finder_if #(.WIDTH(W), .AMT_W(A)) bus ();

  rotation_amount_finder #(.WIDTH(W), .AMT_W(A)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] r, input int n);
    logic [2*W-1:0] t;
    t = {r, r} << (n % W);
    return t[2*W-1:W];
  endfunction

  // Smallest left rotation k taking r to t, mapped to the rotator's (lr, amount) convention.
  task automatic model(input logic [W-1:0] r, input logic [W-1:0] t,
                       output bit f, output bit l, output int amt, output int lat);
    f = 0; l = 0; amt = 0; lat = W;
    for (int kk = 0; kk < W; kk++) begin
      if (!f && rotl(r, kk) == t) begin
        f   = 1;
        lat = kk + 1;
        if (kk <= W / 2) begin l = 1; amt = kk; end
        else begin l = 0; amt = W - kk; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] r, input logic [W-1:0] t,
                           input bit noise);
    bit ef, el, seen;
    int ea, elat, lat;
    model(r, t, ef, el, ea, elat);
    bus.start  = 1'b1;
    bus.ref_in = r;
    bus.rot_in = t;
    tick();
    chk({tag, ".busy_e0"}, bus.busy, 1);
    bus.start  = noise;
    bus.ref_in = W'($urandom);
    bus.rot_in = W'($urandom);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 3 * W) begin
      tick();
      lat++;
      seen = bus.done;
      if (noise && !seen) begin
        bus.ref_in = W'($urandom);
        bus.rot_in = W'($urandom);
      end
    end
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".found"}, bus.found, ef);
    chk({tag, ".lr"}, bus.lr, el);
    chk({tag, ".amount"}, bus.amount, ea);
    tick();
    bus.start = 1'b0;
    chk({tag, ".busy_after"}, bus.busy, 0);
    chk({tag, ".done_after"}, bus.done, 0);
    chk({tag, ".found_hold"}, bus.found, ef);
    chk({tag, ".lr_hold"}, bus.lr, el);
    chk({tag, ".amount_hold"}, bus.amount, ea);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] r, t;
    bus.start  = 1'b0;
    bus.ref_in = '0;
    bus.rot_in = '0;
    #2 rst_n = 1'b0;
    #10;
    chk("reset.busy", bus.busy, 0);
    chk("reset.done", bus.done, 0);
    chk("reset.found", bus.found, 0);
    chk("reset.lr", bus.lr, 0);
    chk("reset.amount", bus.amount, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    run_check("left3", 8'b10010010, 8'b10010100, 0);
    run_check("right2", 8'b10010010, 8'b10100100, 0);
    run_check("periodic", 8'b10101010, 8'b01010101, 0);
    run_check("zeros", 8'b00000000, 8'b00000000, 0);
    run_check("nomatch", 8'b10010010, 8'b11110000, 0);

    r = 8'b10010010;
    for (int i = 0; i < 16; i++) begin
      t = (i >= 8) ? rotl(r, i % 8) : rotl(r, W - (i % 8));
      run_check($sformatf("sweep%0d", i), r, t, (i % 2) == 1);
    end

    for (int i = 0; i < 12; i++) begin
      r = W'($urandom);
      t = ($urandom_range(0, 2) != 0) ? rotl(r, $urandom_range(0, W - 1)) : W'($urandom);
      run_check($sformatf("rand%0d", i), r, t, $urandom_range(0, 1) == 1);
    end

    // Abort a search midway with the async reset.
    r = 8'b10010010;
    run_check("prereset", r, rotl(r, 1), 0);
    bus.start  = 1'b1;
    bus.ref_in = r;
    bus.rot_in = rotl(r, 6);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort.busy", bus.busy, 0);
    chk("abort.done", bus.done, 0);
    chk("abort.found", bus.found, 0);
    chk("abort.lr", bus.lr, 0);
    chk("abort.amount", bus.amount, 0);
    #2 rst_n = 1'b1;
    run_check("post_reset", r, r, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
